// File: rtl/seq_det_pkg.sv
// Shared types, constants and reset-time defaults for the serial-pattern detector.
package seq_det_pkg;

  localparam int unsigned DEF_PATTERN_W = 4;
  localparam int unsigned DEF_CNT_W     = 8;

  typedef logic [DEF_PATTERN_W-1:0] pattern_t;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  localparam pattern_t DEF_PATTERN = 4'b0101;
  localparam logic     DEF_OVERLAP = OVL_ON;

  // True when the counter value has reached its saturation point.
  function automatic logic is_all_ones(input logic [63:0] value, input int unsigned width);
    logic res;
    res = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < width) begin
        res = res & value[i];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; sat is registered alongside count.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             sat_r;
  logic             sat_nxt_s;

  // Next count: clear wins, increments stop once all-ones is reached.
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (inc && !sat_r) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
    sat_nxt_s = is_all_ones(64'(count_nxt_s), CNT_W);
  end

  // Count and saturation flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      sat_r   <= sat_nxt_s;
    end
  end

  assign count = count_r;
  assign sat   = sat_r;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial-pattern detector with overlap control and saturating match count.
// Optional SEQ_DET_REG_OUT_EN registers the match flag (one cycle later); default is Mealy.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned           PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0]  PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter logic                  OVERLAP   = DEF_OVERLAP,
  parameter int unsigned           CNT_W     = DEF_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in,
  input  logic                 cfg_load,
  input  logic [PATTERN_W-1:0] cfg_pattern,
  input  logic                 cfg_overlap,
  output logic                 out,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 cnt_sat
);

  localparam int unsigned HIST_W = PATTERN_W - 1;
  localparam int unsigned FILL_W = $clog2(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W - 1);

  logic [PATTERN_W-1:0] pat_r;
  logic [PATTERN_W-1:0] pat_nxt_s;
  logic                 ovl_r;
  logic                 ovl_nxt_s;
  logic [HIST_W-1:0]    hist_r;
  logic [HIST_W-1:0]    hist_nxt_s;
  logic [FILL_W-1:0]    fill_r;
  logic [FILL_W-1:0]    fill_nxt_s;
  logic [PATTERN_W-1:0] window_s;
  logic                 match_s;

  // The fill gate keeps reset-time zeros in hist from ever matching.
  always_comb begin
    window_s = {hist_r, in};
    match_s  = in_valid & ~cfg_load & (fill_r == FILL_MAX) & (window_s == pat_r);
  end

  // Next-state for pattern, mode, history and fill; cfg_load discards the current bit.
  always_comb begin
    pat_nxt_s  = pat_r;
    ovl_nxt_s  = ovl_r;
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    if (cfg_load) begin
      pat_nxt_s  = cfg_pattern;
      ovl_nxt_s  = cfg_overlap;
      hist_nxt_s = {HIST_W{1'b0}};
      fill_nxt_s = {FILL_W{1'b0}};
    end else if (in_valid) begin
      hist_nxt_s = window_s[HIST_W-1:0];
      if (match_s && !ovl_r) begin
        fill_nxt_s = {FILL_W{1'b0}};
      end else if (fill_r != FILL_MAX) begin
        fill_nxt_s = fill_r + FILL_W'(1);
      end else begin
        fill_nxt_s = fill_r;
      end
    end else begin
      fill_nxt_s = fill_r;
    end
  end

  // Detector state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_r  <= PATTERN;
      ovl_r  <= OVERLAP;
      hist_r <= {HIST_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else begin
      pat_r  <= pat_nxt_s;
      ovl_r  <= ovl_nxt_s;
      hist_r <= hist_nxt_s;
      fill_r <= fill_nxt_s;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cfg_load),
    .inc   (match_s),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

`ifdef SEQ_DET_REG_OUT_EN
  logic out_q;

  // Registered match flag, cleared by a configuration load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q <= 1'b0;
    end else if (cfg_load) begin
      out_q <= 1'b0;
    end else begin
      out_q <= match_s;
    end
  end

  assign out = out_q;
`else
  assign out = match_s;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized
// stream compared against a queue-based reference model.
module tb_seq_detector_param;

  logic       clock;
  logic       reset;
  logic       in_valid, in, cfg_load, cfg_overlap;
  logic [3:0] cfg_pattern;
  logic       out;
  logic [7:0] match_cnt;
  logic       cnt_sat;

  logic       in_valid2, in2, cfg_load2, cfg_overlap2;
  logic [1:0] cfg_pattern2;
  logic       out2;
  logic [1:0] match_cnt2;
  logic       cnt_sat2;

  int n_cmp = 0;
  int n_err = 0;

  seq_detector_param dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .out(out),
    .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.PATTERN_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in(in2), .cfg_load(cfg_load2),
    .cfg_pattern(cfg_pattern2), .cfg_overlap(cfg_overlap2), .out(out2),
    .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle on dut; out sampled mid-cycle, state observable 1 ns after the edge.
  task automatic apply(input logic v, input logic b, input logic ld, input logic [3:0] p,
                       input logic o, output logic got_out);
    @(negedge clock);
    in_valid = v; in = b; cfg_load = ld; cfg_pattern = p; cfg_overlap = o;
    #2;
    got_out = out;
    @(posedge clock);
    #1;
  endtask

  // Reference model: accepted bits since the last restart, kept as a queue.
  logic        mq[$];
  logic [3:0]  m_pat;
  logic        m_ovl;
  int unsigned m_cnt;

  task automatic model_step(input logic v, input logic b, input logic ld, input logic [3:0] p,
                            input logic o, output logic exp_out);
    logic [3:0] w;
    exp_out = 1'b0;
    if (ld) begin
      m_pat = p; m_ovl = o; mq.delete(); m_cnt = 0;
    end else if (v) begin
      if (mq.size() >= 3) begin
        w = {mq[mq.size()-3], mq[mq.size()-2], mq[mq.size()-1], b};
        exp_out = (w == m_pat);
      end
      mq.push_back(b);
      if (mq.size() > 3) void'(mq.pop_front());
      if (exp_out) begin
        if (m_cnt < 255) m_cnt++;
        if (!m_ovl) mq.delete();
      end
    end
  endtask

  typedef struct {
    logic       vld;
    logic       b;
    logic       ld;
    logic [3:0] pat;
    logic       ovl;
    logic       exp_out;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic v, input logic b, input logic ld, input logic [3:0] p,
                              input logic o, input logic eo, input logic [7:0] ec);
    vec_t r;
    r.vld = v; r.b = b; r.ld = ld; r.pat = p; r.ovl = o; r.exp_out = eo; r.exp_cnt = ec;
    return r;
  endfunction

  initial begin
    logic got;
    logic eo;
    logic [3:0] p0101;
    int pulses;
    int pulse_at;
    int vcount;
    p0101 = 4'b0101;

    in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'b0000; cfg_overlap = 1'b0;
    in_valid2 = 1'b0; in2 = 1'b0; cfg_load2 = 1'b0; cfg_pattern2 = 2'b00; cfg_overlap2 = 1'b0;
    reset = 1'b0;
    #12;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_cnt", 32'(match_cnt), 32'd0);
    chk("reset_sat", 32'(cnt_sat), 32'd0);
    chk("reset_cnt2", 32'(match_cnt2), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Test 1: defaults, overlapping.
    vt.push_back(mk(1,0,0,0,0, 0,0)); vt.push_back(mk(1,1,0,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0)); vt.push_back(mk(1,1,0,0,0, 1,1));
    vt.push_back(mk(1,0,0,0,0, 0,1)); vt.push_back(mk(1,1,0,0,0, 1,2));
    vt.push_back(mk(1,0,0,0,0, 0,2)); vt.push_back(mk(1,1,0,0,0, 1,3));
    // Test 2: load 0101 non-overlapping (load cycle carries a valid bit that is discarded).
    vt.push_back(mk(1,1,1,p0101,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0)); vt.push_back(mk(1,1,0,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0)); vt.push_back(mk(1,1,0,0,0, 1,1));
    vt.push_back(mk(1,0,0,0,0, 0,1)); vt.push_back(mk(1,1,0,0,0, 0,1));
    vt.push_back(mk(1,0,0,0,0, 0,1)); vt.push_back(mk(1,1,0,0,0, 1,2));
    // Test 4: load on the completing bit discards it and restarts fill.
    vt.push_back(mk(0,0,1,p0101,1, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0)); vt.push_back(mk(1,1,0,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0));
    vt.push_back(mk(1,1,1,p0101,1, 0,0));
    vt.push_back(mk(1,1,0,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0)); vt.push_back(mk(1,1,0,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0)); vt.push_back(mk(1,1,0,0,0, 1,1));

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].vld, vt[i].b, vt[i].ld, vt[i].pat, vt[i].ovl, got);
      chk($sformatf("vec%0d_out", i), 32'(got), 32'(vt[i].exp_out));
      chk($sformatf("vec%0d_cnt", i), 32'(match_cnt), 32'(vt[i].exp_cnt));
    end

    // Test 3: gaps of three invalid cycles (with in=1 driven) do not break the match.
    apply(0, 0, 1, p0101, 1, got);
    pulses = 0; pulse_at = -1; vcount = 0;
    for (int k = 0; k < 4; k++) begin
      apply(1, p0101[3-k], 0, 0, 0, got);
      vcount++;
      if (got) begin pulses++; pulse_at = vcount; end
      for (int g = 0; g < 3; g++) begin
        apply(0, 1, 0, 0, 0, got);
        if (got) pulses++;
      end
    end
    chk("gap_pulses", 32'(pulses), 32'd1);
    chk("gap_pulse_pos", 32'(pulse_at), 32'd4);
    chk("gap_cnt", 32'(match_cnt), 32'd1);

    // Test 5: narrow counter saturates on dut2.
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      in_valid2 = 1'b1; in2 = 1'b1;
      #2;
      chk($sformatf("sat_out%0d", k), 32'(out2), (k == 0) ? 32'd0 : 32'd1);
      @(posedge clock);
      #1;
      chk($sformatf("sat_cnt%0d", k), 32'(match_cnt2), (k >= 3) ? 32'd3 : 32'(k));
      chk($sformatf("sat_flag%0d", k), 32'(cnt_sat2), (k >= 3) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    in_valid2 = 1'b0;

    // Test 6: reset mid-stream loses history and restores defaults.
    apply(1, 0, 0, 0, 0, got); apply(1, 1, 0, 0, 0, got); apply(1, 0, 0, 0, 0, got);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b1; in = 1'b1;
    #2;
    chk("rst_hold_out", 32'(out), 32'd0);
    chk("rst_hold_cnt", 32'(match_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;
    apply(1, 1, 0, 0, 0, got);
    chk("rst_after_out", 32'(got), 32'd0);
    apply(1, 0, 0, 0, 0, got); chk("rst_seq0", 32'(got), 32'd0);
    apply(1, 1, 0, 0, 0, got); chk("rst_seq1", 32'(got), 32'd0);
    apply(1, 0, 0, 0, 0, got); chk("rst_seq2", 32'(got), 32'd0);
    apply(1, 1, 0, 0, 0, got); chk("rst_seq3", 32'(got), 32'd1);

    // Randomized stream against the reference model.
    model_step(0, 0, 1, p0101, 1, eo);
    apply(0, 0, 1, p0101, 1, got);
    for (int n = 0; n < 3000; n++) begin
      logic v, b, ld, o;
      logic [3:0] p;
      v  = ($urandom_range(3, 0) != 0);
      b  = $urandom_range(1, 0) != 0;
      ld = ($urandom_range(79, 0) == 0);
      p  = 4'($urandom_range(15, 0));
      o  = $urandom_range(1, 0) != 0;
      model_step(v, b, ld, p, o, eo);
      apply(v, b, ld, p, o, got);
      chk($sformatf("rnd%0d_out", n), 32'(got), 32'(eo));
      chk($sformatf("rnd%0d_cnt", n), 32'(match_cnt), 32'(m_cnt));
      chk($sformatf("rnd%0d_sat", n), 32'(cnt_sat), (m_cnt == 255) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
